motion_cmd_executor: RTL and testbench
======================================

// Module: motion_cmd_executor
// PURPOSE
//  Responder side of the robot motion-command interface. Accepts one move command at a time
//  over valid/ready: forward, reverse, spin-left or spin-right, for N encoder ticks at a given duty.
//  Drives both motor channels (en/dir/pwm) and counts wheel-encoder edges.
//  Reports completion with status. Sits between the behaviour FSM in fpga_top and the TI-RSLK motor pins.
// PARAMETERS
//  TICK_W        12       width of tick target and tick counters
//  DUTY_W        16       width of duty value (WF_CLK cycles high per PWM period)
//  PWM_PERIOD    16000    PWM period in WF_CLK cycles (1 kHz at 16 MHz)
//  STALL_CYCLES  1600000  max cycles without an encoder edge on a driven wheel (STALL_DETECT_EN only)
// PORTS
//  WF_CLK        in   1       system clock
//  WF_RSTN       in   1       asynchronous active-low reset
//  cmd_valid     in   1       command offered
//  cmd_ready     out  1       executor can accept a command (IDLE only)
//  cmd_op        in   2       00 fwd, 01 rev, 10 spin-left, 11 spin-right
//  cmd_ticks     in   TICK_W  encoder rising edges per wheel to travel
//  cmd_duty      in   DUTY_W  PWM high time in cycles; >=PWM_PERIOD means 100%
//  abort         in   1       stop current move (e.g. bumper hit); level-sensitive
//  motorL_encdr  in   1       left encoder, asynchronous
//  motorR_encdr  in   1       right encoder, asynchronous
//  motorL_en     out  1       left driver enable (sleep_n)
//  motorL_dir    out  1       left direction, 1 = backward
//  motorL_pwm    out  1       left PWM
//  motorR_en     out  1       right driver enable (sleep_n)
//  motorR_dir    out  1       right direction, 1 = backward
//  motorR_pwm    out  1       right PWM
//  busy          out  1       command in progress (RUN or DONE)
//  done          out  1       1-cycle pulse at move end
//  status        out  2       00 ok, 01 aborted, 10 stalled; held until next accept
//  ticksL        out  TICK_W  left edges counted this move
//  ticksR        out  TICK_W  right edges counted this move
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters 0, status 00. motor*_en = 1 from first cycle after reset release.
//  Encoders: 2-flop synchroniser, then rising-edge detect. Edge counted 3 cycles after the pin edge.
//  IDLE:
//   - cmd_ready=1; accept on cmd_valid&cmd_ready.
//   - On accept: latch op/ticks/duty, clear ticksL/R and status, restart PWM counters at 0.
//   - cmd_ticks==0: go to DONE, status 00, no PWM pulse.
//   - abort in IDLE is ignored.
//  RUN (entered the cycle after accept):
//   - cmd_ready=0; dir from op: fwd L0/R0, rev L1/R1, spin-left L1/R0, spin-right L0/R1.
//   - Each wheel counts edges; a wheel's PWM is forced low from the cycle its count reaches target.
//   - Counter saturates at target; further edges are ignored.
//   - Both wheels at target: go to DONE with status 00.
//   - abort=1: go to DONE next cycle with status 01; both PWMs low immediately (combinational gate).
//   - abort and completion in the same cycle: abort wins.
//  DONE:
//   - PWMs low, done=1 for exactly one cycle, then IDLE. dir holds its last value until the next accept.
//  PWM:
//   - Counter 0..PWM_PERIOD-1; out = (cnt < duty).
//   - duty is sampled at cnt==0; duty 0 gives constant low.
//  Reset mid-move: outputs return to reset values asynchronously; the move is lost with no done pulse.
// CONFIGURATION
//  STALL_DETECT_EN defined:
//   - Per-wheel watchdog counts cycles since that wheel's last edge while its PWM is enabled.
//   - Watchdog is cleared on each edge.
//   - Reaching STALL_CYCLES: DONE with status 10. abort takes priority over stall.
//  Undefined: no watchdog logic; status 10 is never produced.
// STRUCTURE
//  robot_pkg:
//   - OP_FWD/OP_REV/OP_SPINL/OP_SPINR.
//   - ST_OK/ST_ABORT/ST_STALL.
//   - FSM state encodings (IDLE/RUN/DONE).
//   - PWM_PERIOD default.
//  Sub-module pwm_gen (counter + compare, restart input), instantiated once per wheel.
//  Synchroniser/edge-detect and FSM are kept inline.
// TESTING
//  - fwd, ticks=5, duty=4000, 5 edges per wheel -> dir L0/R0; PWM 25% (4000/16000); done at 5th edge +3..4 cycles; status 00; ticksL=ticksR=5.
//  - spin-right, ticks=3; left gets 3 edges, right gets 1 -> motorL_pwm low after L=3, right keeps driving; done only after R=3.
//  - rev, ticks=100, abort raised after 10 edges -> both PWMs low the same cycle; done next cycle; status 01; ticks=10.
//  - cmd_ticks=0 -> no PWM high; done 2 cycles after accept; status 00. cmd_valid held in RUN -> cmd_ready stays 0, no second accept.
//  - WF_RSTN low mid-RUN -> all outputs 0 asynchronously; after release IDLE with cmd_ready=1 and no done pulse.
//  - STALL_DETECT_EN with STALL_CYCLES=1000, no encoder edges -> done at cycle 1000 of RUN, status 10; abort at the same cycle -> status 01.

Source files
------------

// File: rtl/robot_pkg.sv
// Shared definitions for the motion-command executor: opcodes, status codes,
// FSM state encoding, PWM period default and the opcode-to-direction helper.
package robot_pkg;

    localparam logic [1:0] OP_FWD   = 2'b00;
    localparam logic [1:0] OP_REV   = 2'b01;
    localparam logic [1:0] OP_SPINL = 2'b10;
    localparam logic [1:0] OP_SPINR = 2'b11;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ABORT = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;

    localparam int PWM_PERIOD_DEF = 16000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Returns {left_dir, right_dir}; 1 = backward.
    function automatic logic [1:0] op_dir(input logic [1:0] op);
        logic [1:0] d;
        case (op)
            OP_FWD:   d = 2'b00;
            OP_REV:   d = 2'b11;
            OP_SPINL: d = 2'b10;
            default:  d = 2'b01;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM: counter 0..PERIOD-1, output high while cnt < duty.
// Ports: clk, rst_n, restart (sync counter clear), duty, pwm.
module pwm_gen
#(
    parameter int DUTY_W = 16,
    parameter int PERIOD = 16000
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0]     cnt_q;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            if (restart || cnt_q == LAST)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '0)
                duty_q <= duty;
        end
    end

    // Duty takes effect at the start of each period, including period 0.
    assign duty_eff = (cnt_q == '0) ? duty : duty_q;
    assign pwm = {{DUTY_W{1'b0}}, cnt_q} < {{CW{1'b0}}, duty_eff};

endmodule

// File: rtl/motion_cmd_executor.sv
// Motion-command executor: accepts one move over valid/ready, drives both
// motor channels (en/dir/pwm), counts encoder edges and reports status.
// Ports: WF_CLK, WF_RSTN, cmd_valid/ready/op/ticks/duty, abort,
//   motorL/R_encdr in; motorL/R_en/dir/pwm, busy, done, status, ticksL/R out.
// Build option: STALL_DETECT_EN adds per-wheel stall watchdogs (status 10).
module motion_cmd_executor
    import robot_pkg::*;
#(
    parameter int TICK_W       = 12,
    parameter int DUTY_W       = 16,
    parameter int PWM_PERIOD   = PWM_PERIOD_DEF,
    parameter int STALL_CYCLES = 1600000
)(
    input  logic              WF_CLK,
    input  logic              WF_RSTN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [TICK_W-1:0] cmd_ticks,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              abort,
    input  logic              motorL_encdr,
    input  logic              motorR_encdr,
    output logic              motorL_en,
    output logic              motorL_dir,
    output logic              motorL_pwm,
    output logic              motorR_en,
    output logic              motorR_dir,
    output logic              motorR_pwm,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [TICK_W-1:0] ticksL,
    output logic [TICK_W-1:0] ticksR
);

    state_t            state_q, state_d;
    logic [1:0]        status_q, status_d;
    logic              en_q;
    logic [2:0]        syncL_q, syncR_q;
    logic [TICK_W-1:0] tgt_q, ticksL_q, ticksR_q;
    logic [DUTY_W-1:0] duty_q;
    logic              dirL_q, dirR_q;
    logic              accept, run, counting;
    logic              edgeL, edgeR, atL, atR;
    logic              rawL, rawR, stall;

    assign run      = (state_q == S_RUN);
    assign accept   = cmd_valid && cmd_ready;
    assign counting = run && !abort;
    assign edgeL    = syncL_q[1] && !syncL_q[2];
    assign edgeR    = syncR_q[1] && !syncR_q[2];
    assign atL      = (ticksL_q == tgt_q);
    assign atR      = (ticksR_q == tgt_q);

    always_ff @(posedge WF_CLK or negedge WF_RSTN) begin
        if (!WF_RSTN) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // A zero-tick move passes through RUN for one cycle with both wheels
    // already at target, so it finishes without any PWM pulse.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        unique case (state_q)
            S_IDLE: if (accept) begin
                state_d  = S_RUN;
                status_d = ST_OK;
            end
            S_RUN: begin
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else if (stall) begin
                    state_d  = S_DONE;
                    status_d = ST_STALL;
                end else if (atL && atR) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge WF_CLK or negedge WF_RSTN) begin
        if (!WF_RSTN) begin
            en_q     <= 1'b0;
            syncL_q  <= '0;
            syncR_q  <= '0;
            tgt_q    <= '0;
            duty_q   <= '0;
            dirL_q   <= 1'b0;
            dirR_q   <= 1'b0;
            ticksL_q <= '0;
            ticksR_q <= '0;
        end else begin
            en_q    <= 1'b1;
            syncL_q <= {syncL_q[1:0], motorL_encdr};
            syncR_q <= {syncR_q[1:0], motorR_encdr};
            if (accept) begin
                tgt_q            <= cmd_ticks;
                duty_q           <= cmd_duty;
                {dirL_q, dirR_q} <= op_dir(cmd_op);
                ticksL_q         <= '0;
                ticksR_q         <= '0;
            end else if (counting) begin
                if (edgeL && !atL)
                    ticksL_q <= ticksL_q + 1'b1;
                if (edgeR && !atR)
                    ticksR_q <= ticksR_q + 1'b1;
            end
        end
    end

`ifdef STALL_DETECT_EN
    localparam int WD_W = $clog2(STALL_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_CYCLES - 1);

    logic [WD_W-1:0] wdL_q, wdR_q;

    // A watchdog only runs while its wheel is still being driven.
    always_ff @(posedge WF_CLK or negedge WF_RSTN) begin
        if (!WF_RSTN) begin
            wdL_q <= '0;
            wdR_q <= '0;
        end else begin
            if (!run || edgeL || atL)
                wdL_q <= '0;
            else
                wdL_q <= wdL_q + 1'b1;
            if (!run || edgeR || atR)
                wdR_q <= '0;
            else
                wdR_q <= wdR_q + 1'b1;
        end
    end

    assign stall = run && ((!atL && wdL_q == WD_LAST) ||
                           (!atR && wdR_q == WD_LAST));
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^STALL_CYCLES;
    assign stall = 1'b0;
`endif

    pwm_gen #(.DUTY_W(DUTY_W), .PERIOD(PWM_PERIOD)) u_pwm_l (
        .clk     (WF_CLK),
        .rst_n   (WF_RSTN),
        .restart (accept),
        .duty    (duty_q),
        .pwm     (rawL)
    );

    pwm_gen #(.DUTY_W(DUTY_W), .PERIOD(PWM_PERIOD)) u_pwm_r (
        .clk     (WF_CLK),
        .rst_n   (WF_RSTN),
        .restart (accept),
        .duty    (duty_q),
        .pwm     (rawR)
    );

    // abort gates PWM combinationally so the motors stop in the same cycle.
    assign motorL_pwm = counting && !atL && rawL;
    assign motorR_pwm = counting && !atR && rawR;
    assign motorL_en  = en_q;
    assign motorR_en  = en_q;
    assign motorL_dir = dirL_q;
    assign motorR_dir = dirR_q;
    assign cmd_ready  = en_q && (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign status     = status_q;
    assign ticksL     = ticksL_q;
    assign ticksR     = ticksR_q;

endmodule

// File: tb/tb_motion_cmd_executor.sv
// Directed bench for motion_cmd_executor: fwd, spin, abort, zero-tick,
// held-valid and mid-move reset cases with hand-computed expectations.
module tb_motion_cmd_executor;

    localparam int TICK_W = 12;
    localparam int DUTY_W = 16;
    localparam int PERIOD = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [TICK_W-1:0] cmd_ticks = '0;
    logic [DUTY_W-1:0] cmd_duty = '0;
    logic              abort = 1'b0;
    logic              encL = 1'b0;
    logic              encR = 1'b0;
    logic              enL, dirL, pwmL, enR, dirR, pwmR;
    logic              busy, done;
    logic [1:0]        status;
    logic [TICK_W-1:0] ticksL, ticksR;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int rise_cyc = 0;
    int hiL = 0;
    int hiR = 0;

    motion_cmd_executor #(
        .TICK_W(TICK_W), .DUTY_W(DUTY_W),
        .PWM_PERIOD(PERIOD), .STALL_CYCLES(1000)
    ) dut (
        .WF_CLK(clk), .WF_RSTN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ticks(cmd_ticks), .cmd_duty(cmd_duty),
        .abort(abort),
        .motorL_encdr(encL), .motorR_encdr(encR),
        .motorL_en(enL), .motorL_dir(dirL), .motorL_pwm(pwmL),
        .motorR_en(enR), .motorR_dir(dirR), .motorR_pwm(pwmR),
        .busy(busy), .done(done), .status(status),
        .ticksL(ticksL), .ticksR(ticksR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (cmd_valid && cmd_ready) acc_cnt = acc_cnt + 1;
        if (pwmL) hiL = hiL + 1;
        if (pwmR) hiR = hiR + 1;
    end

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        done_cnt = 0;
        acc_cnt = 0;
        hiL = 0;
        hiR = 0;
    endtask

    task automatic issue(input logic [1:0] op, input int t, input int d);
        cmd_op = op;
        cmd_ticks = TICK_W'(t);
        cmd_duty = DUTY_W'(d);
        cmd_valid = 1'b1;
        tick(1);
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic edges(input int nl, input int nr);
        int n;
        n = (nl > nr) ? nl : nr;
        for (int i = 0; i < n; i++) begin
            encL = (i < nl);
            encR = (i < nr);
            rise_cyc = cyc;
            tick(2);
            encL = 1'b0;
            encR = 1'b0;
            tick(2);
        end
    endtask

    initial begin
        // reset state
        tick(2);
        expect_eq("rst_outs",
                  {enL, enR, dirL, dirR, pwmL, pwmR, busy, done,
                   cmd_ready, status, ticksL, ticksR}, 0);
        rst_n = 1'b1;
        tick(1);
        expect_eq("rel_en", {enL, enR}, 2'b11);
        expect_eq("rel_ready", cmd_ready, 1);

        // fwd 5 ticks, 25% duty
        clr_mon();
        issue(2'b00, 5, 4);
        clr_mon();
        tick(16);
        expect_eq("fwd_hiL", hiL, 4);
        expect_eq("fwd_hiR", hiR, 4);
        expect_eq("fwd_dir", {dirL, dirR}, 2'b00);
        expect_eq("fwd_busy_rdy", {busy, cmd_ready}, 2'b10);
        edges(5, 5);
        tick(4);
        expect_eq("fwd_done_cnt", done_cnt, 1);
        expect_eq("fwd_done_lat",
                  (done_cyc - rise_cyc >= 3) && (done_cyc - rise_cyc <= 4), 1);
        expect_eq("fwd_ticks", {ticksL, ticksR}, {12'd5, 12'd5});
        expect_eq("fwd_status", status, 0);
        expect_eq("fwd_idle", {busy, pwmL, pwmR, cmd_ready}, 4'b0001);

        // spin-right 3 ticks, 100% duty, extra left edge saturates
        clr_mon();
        issue(2'b11, 3, 16);
        edges(4, 1);
        tick(2);
        expect_eq("spr_dir", {dirL, dirR}, 2'b01);
        expect_eq("spr_ticksL_sat", ticksL, 3);
        expect_eq("spr_ticksR", ticksR, 1);
        expect_eq("spr_pwm", {pwmL, pwmR}, 2'b01);
        expect_eq("spr_no_done", {done_cnt[0], busy}, 2'b01);
        edges(0, 2);
        tick(4);
        expect_eq("spr_done_cnt", done_cnt, 1);
        expect_eq("spr_ticksR_end", ticksR, 3);
        expect_eq("spr_status", status, 0);
        expect_eq("spr_dir_hold", {dirL, dirR}, 2'b01);

        // rev 100 ticks, abort after 10 edges
        clr_mon();
        issue(2'b01, 100, 16);
        edges(10, 10);
        tick(2);
        expect_eq("rev_dir", {dirL, dirR}, 2'b11);
        expect_eq("rev_pwm_on", {pwmL, pwmR}, 2'b11);
        abort = 1'b1;
        #1;
        expect_eq("abort_pwm_off", {pwmL, pwmR}, 2'b00);
        tick(1);
        expect_eq("abort_done", done, 1);
        expect_eq("abort_status", status, 1);
        expect_eq("abort_ticks", {ticksL, ticksR}, {12'd10, 12'd10});
        tick(4);
        expect_eq("abort_idle_ign", {cmd_ready, busy, status}, 4'b1001);
        expect_eq("abort_done_cnt", done_cnt, 1);
        abort = 1'b0;

        // zero-tick move
        clr_mon();
        issue(2'b00, 0, 16);
        tick(4);
        expect_eq("zero_done_cnt", done_cnt, 1);
        expect_eq("zero_done_lat",
                  (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);
        expect_eq("zero_no_pwm", hiL + hiR, 0);
        expect_eq("zero_status", status, 0);

        // cmd_valid held through RUN
        clr_mon();
        cmd_op = 2'b00;
        cmd_ticks = 12'd3;
        cmd_duty = 16'd8;
        cmd_valid = 1'b1;
        tick(10);
        expect_eq("held_acc_cnt", acc_cnt, 1);
        expect_eq("held_rdy_busy", {cmd_ready, busy}, 2'b01);
        cmd_valid = 1'b0;
        abort = 1'b1;
        tick(2);
        abort = 1'b0;
        tick(1);
        expect_eq("held_end", {busy, status}, 3'b001);

        // reset mid-RUN
        clr_mon();
        issue(2'b01, 5, 16);
        tick(3);
        expect_eq("mid_run", {busy, pwmL, dirL}, 3'b111);
        rst_n = 1'b0;
        #1;
        expect_eq("mid_rst_outs",
                  {enL, enR, dirL, dirR, pwmL, pwmR, busy, done,
                   cmd_ready, status, ticksL, ticksR}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        expect_eq("post_rst_ready", {cmd_ready, busy, enL}, 3'b101);
        expect_eq("post_rst_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
